// File: rtl/mul_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mul_seq_pkg
// Purpose : Shared constants for the sequential shift-add multiplier:
//           default operand width, FSM state encodings and the counter
//           width helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mul_seq_pkg;

  localparam int XLEN_DEF = 32;

  // FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // One extra bit so the counter can hold the value XLEN without wrapping.
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(XLEN_DEF);

endpackage
`default_nettype wire

// File: rtl/mul_seq_dp.sv
`default_nettype none
// ============================================================================
// Module  : mul_seq_dp
// Purpose : Shift-add datapath: multiplicand, multiplier and accumulator
//           registers plus the accumulating adder.
// Ports   : clk_i, rst_i (async, active-low)
//           load_i          - capture a_i/b_i, clear accumulator
//           step_i          - perform one shift-add iteration
//           a_i, b_i        - operands
//           acc_o           - accumulator (product once finished)
//           mplier_done_o   - multiplier becomes zero after this step
// Revision: 1.0 - initial release
// ============================================================================
module mul_seq_dp
  import mul_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] acc_o,
  output logic            mplier_done_o
);

  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
    end else if (step_i) begin
      // Adder wraps modulo 2^XLEN; only the low product bits are kept.
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign acc_o = acc_q;
  // Early-out: the multiplier after the current shift has no set bits left.
  assign mplier_done_o = (mplier_q[XLEN-1:1] == '0);

endmodule
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : mul_seq
// Purpose : Sequential unsigned multiplier (low XLEN bits) with valid/ready
//           request and response handshakes, early-out and pipeline flush.
// Ports   : clk_i, rst_i (async, active-low)
//           req_valid_i / req_ready_o - request handshake, operands a_i, b_i
//           rsp_valid_o / rsp_ready_i - response handshake, product result_o
//           flush_i                   - abort, returns to IDLE next edge
//           busy_o                    - FSM not idle (pipeline stall)
// Revision: 1.0 - initial release
// ============================================================================
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CNT_W = cnt_width(XLEN);
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_load;
  logic             w_step;
  logic             w_mplier_done;
  logic [XLEN-1:0]  w_acc;

  assign w_cnt_inc = cnt_q + c_CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_load  = 1'b0;
    w_step  = 1'b0;
    // Flush wins over accept, iteration and response handshake.
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            w_load  = 1'b1;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
        S_BUSY: begin
          w_step = 1'b1;
          cnt_d  = w_cnt_inc;
          if (w_mplier_done || (w_cnt_inc == c_CNT_MAX)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready_i) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mul_seq_dp #(
    .XLEN (XLEN)
  ) u_dp (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_i        (w_load),
    .step_i        (w_step),
    .a_i           (a_i),
    .b_i           (b_i),
    .acc_o         (w_acc),
    .mplier_done_o (w_mplier_done)
  );

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign result_o    = (state_q == S_DONE) ? w_acc : '0;

endmodule
`default_nettype wire
